// File: rtl/trace_checker.sv
// rtl/trace_checker.sv - commit-stream checker against a golden expected-trace memory
//
// Purpose: buffers the CPU commit stream in a small FIFO, prefetches golden
// trace records from an external memory into a 2-entry skid buffer, and
// compares one commit per cycle in program order. Reports the first error.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   commit_vld          one instruction retires this cycle
//   pc, reg_wr, wr_reg, wr_data, mem_wr, mem_addr, mem_data, hlt
//                       retiring instruction's effects
//   exp_rd, exp_addr    expected-memory read strobe and entry index
//   exp_entry           returned entry, valid 1 cycle after exp_rd
//                       {kind[53:52], pc[51:36], reg[35:32], addr[31:16], data[15:0]}
//   done, pass          check finished / finished without error
//   err_idx, err_code   first failing instruction number and error code
//   checked             number of commits compared
//
// Optional feature: define TRACE_CHECK_PC_EN to compare the PC field of
// every record (err_code 2). Left undefined, the PC field is ignored.

module trace_checker #(
    parameter int DEPTH      = 4,
    parameter int MAX_CYCLES = 1000,
    parameter int IDX_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             commit_vld,
    input  logic [15:0]      pc,
    input  logic             reg_wr,
    input  logic [3:0]       wr_reg,
    input  logic [15:0]      wr_data,
    input  logic             mem_wr,
    input  logic [15:0]      mem_addr,
    input  logic [15:0]      mem_data,
    input  logic             hlt,
    output logic             exp_rd,
    output logic [IDX_W-1:0] exp_addr,
    input  logic [53:0]      exp_entry,
    output logic             done,
    output logic             pass,
    output logic [IDX_W-1:0] err_idx,
    output logic [2:0]       err_code,
    output logic [IDX_W-1:0] checked
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int CYC_W = $clog2(MAX_CYCLES + 1);

    localparam logic [1:0] RUN       = 2'd0;
    localparam logic [1:0] DONE_PASS = 2'd1;
    localparam logic [1:0] DONE_FAIL = 2'd2;

    localparam logic [2:0] ERR_OK       = 3'd0;
    localparam logic [2:0] ERR_KIND     = 3'd1;
    localparam logic [2:0] ERR_PC       = 3'd2;
    localparam logic [2:0] ERR_REG      = 3'd3;
    localparam logic [2:0] ERR_ADDR     = 3'd4;
    localparam logic [2:0] ERR_DATA     = 3'd5;
    localparam logic [2:0] ERR_OVERFLOW = 3'd6;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd7;

    logic [1:0]       state;
    logic             running;
    logic [CYC_W-1:0] cycleCnt;

    // Commit classification. An illegal commit (register and memory write
    // together) is carried through the FIFO with a flag so that it fails at
    // its own position in program order.
    logic        cIllegal;
    logic [1:0]  cKind;
    logic [15:0] cData;
    logic [54:0] cEntry;

    always_comb begin
        cIllegal = 1'b0;
        cKind    = 2'd0;
        if (hlt)
            cKind = 2'd3;
        else if (reg_wr && mem_wr)
            cIllegal = 1'b1;
        else if (reg_wr)
            cKind = 2'd1;
        else if (mem_wr)
            cKind = 2'd2;
        cData = (cKind == 2'd1) ? wr_data : (cKind == 2'd2) ? mem_data : 16'h0000;
    end

    assign cEntry = {cIllegal, cKind, pc, wr_reg, mem_addr, cData};

    // Commit FIFO
    logic [54:0]      fifoMem [DEPTH];
    logic [PTR_W-1:0] fifoWp, fifoRp;
    logic [CNT_W-1:0] fifoCnt;
    logic             pushReq, fifoFull, push, overflow;

    // Skid buffer for returned expected entries
    logic [53:0] skidMem [2];
    logic        skidWp, skidRp;
    logic [1:0]  skidCnt;
    logic        inFlight;
    logic        retLoad;
    logic [IDX_W-1:0] rdPtr;

    logic doCmp;

    assign running  = (state == RUN);
    assign pushReq  = running && commit_vld;
    assign fifoFull = (fifoCnt == CNT_W'(DEPTH));
    assign push     = pushReq && !fifoFull;
    assign overflow = pushReq && fifoFull;
    assign doCmp    = running && (fifoCnt != '0) && (skidCnt != 2'd0);
    assign retLoad  = inFlight;

    // Count the entry popped this cycle as already gone, otherwise a full
    // pipeline would alternate read/no-read and halve compare throughput.
    assign exp_rd   = rst_n && running &&
                      (({1'b0, skidCnt} + {2'b00, inFlight}) < (doCmp ? 3'd3 : 3'd2));
    assign exp_addr = rdPtr;

    always_ff @(posedge clk) begin
        if (push)
            fifoMem[fifoWp] <= cEntry;
        if (retLoad)
            skidMem[skidWp] <= exp_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifoWp   <= '0;
            fifoRp   <= '0;
            fifoCnt  <= '0;
            skidWp   <= 1'b0;
            skidRp   <= 1'b0;
            skidCnt  <= 2'd0;
            inFlight <= 1'b0;
            rdPtr    <= '0;
        end else begin
            if (push)
                fifoWp <= fifoWp + PTR_W'(1);
            if (doCmp)
                fifoRp <= fifoRp + PTR_W'(1);
            fifoCnt  <= fifoCnt + CNT_W'(push) - CNT_W'(doCmp);
            if (retLoad)
                skidWp <= ~skidWp;
            if (doCmp)
                skidRp <= ~skidRp;
            skidCnt  <= skidCnt + 2'(retLoad) - 2'(doCmp);
            inFlight <= exp_rd;
            rdPtr    <= rdPtr + IDX_W'(exp_rd);
        end
    end

    // Field compare of FIFO head against skid head
    logic [54:0] head;
    logic [53:0] expHead;
    logic        hIllegal;
    logic [1:0]  hKind, eKind;
    logic [15:0] hPc, ePc, hAddr, eAddr, hData, eData;
    logic [3:0]  hReg, eReg;
    logic [2:0]  cmpCode;

    assign head    = fifoMem[fifoRp];
    assign expHead = skidMem[skidRp];
    assign {hIllegal, hKind, hPc, hReg, hAddr, hData} = head;
    assign {eKind, ePc, eReg, eAddr, eData}           = expHead;

`ifndef TRACE_CHECK_PC_EN
    logic unusedPc;
    assign unusedPc = ^{hPc, ePc};
`endif

    always_comb begin
        cmpCode = ERR_OK;
        if (hIllegal || (hKind != eKind))
            cmpCode = ERR_KIND;
`ifdef TRACE_CHECK_PC_EN
        else if (hPc != ePc)
            cmpCode = ERR_PC;
`endif
        else if ((hKind == 2'd1) && (hReg != eReg))
            cmpCode = ERR_REG;
        else if ((hKind == 2'd2) && (hAddr != eAddr))
            cmpCode = ERR_ADDR;
        else if (((hKind == 2'd1) || (hKind == 2'd2)) && (hData != eData))
            cmpCode = ERR_DATA;
    end

    // Result FSM. A compare outcome outranks overflow and timeout in the same
    // cycle because it concerns an older instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            cycleCnt <= '0;
            checked  <= '0;
            err_idx  <= '0;
            err_code <= ERR_OK;
            pass     <= 1'b0;
        end else if (running) begin
            cycleCnt <= cycleCnt + CYC_W'(1);
            if (doCmp)
                checked <= checked + IDX_W'(1);
            if (doCmp && (cmpCode != ERR_OK)) begin
                state    <= DONE_FAIL;
                err_code <= cmpCode;
                err_idx  <= checked;
            end else if (doCmp && (hKind == 2'd3)) begin
                state <= DONE_PASS;
                pass  <= 1'b1;
            end else if (overflow) begin
                state    <= DONE_FAIL;
                err_code <= ERR_OVERFLOW;
                err_idx  <= checked;
            end else if (cycleCnt == CYC_W'(MAX_CYCLES - 1)) begin
                state    <= DONE_FAIL;
                err_code <= ERR_TIMEOUT;
                err_idx  <= checked;
            end
        end
    end

    assign done = (state != RUN);

endmodule

// File: tb/tb_trace_checker.sv
// tb/tb_trace_checker.sv - self-checking bench for trace_checker
`timescale 1ns/1ps

module tb_trace_checker;

    localparam int DEPTH = 4;
    localparam int MAXC  = 300;
    localparam int IDX_W = 16;
`ifdef TRACE_CHECK_PC_EN
    localparam bit PC_EN = 1'b1;
`else
    localparam bit PC_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             commit_vld;
    logic [15:0]      pc;
    logic             reg_wr;
    logic [3:0]       wr_reg;
    logic [15:0]      wr_data;
    logic             mem_wr;
    logic [15:0]      mem_addr;
    logic [15:0]      mem_data;
    logic             hlt;
    logic             exp_rd;
    logic [IDX_W-1:0] exp_addr;
    logic [53:0]      exp_entry;
    logic             done;
    logic             pass;
    logic [IDX_W-1:0] err_idx;
    logic [2:0]       err_code;
    logic [IDX_W-1:0] checked;

    int vectors = 0;
    int miscompares = 0;

    trace_checker #(.DEPTH(DEPTH), .MAX_CYCLES(MAXC), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .commit_vld(commit_vld), .pc(pc),
        .reg_wr(reg_wr), .wr_reg(wr_reg), .wr_data(wr_data), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_data(mem_data), .hlt(hlt),
        .exp_rd(exp_rd), .exp_addr(exp_addr), .exp_entry(exp_entry),
        .done(done), .pass(pass), .err_idx(err_idx), .err_code(err_code),
        .checked(checked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hlt, regWr, memWr;
        logic [15:0] pc, wrData, memAddr, memData;
        logic [3:0]  wrReg;
    } commit_t;

    commit_t     prog [64];
    logic [53:0] expMem [64];
    int          nProg;

    // Expected-trace memory: data only valid the cycle after a read.
    logic [63:0] junk;
    always @(posedge clk) begin
        junk = {$urandom, $urandom};
        if (exp_rd)
            exp_entry <= expMem[exp_addr[5:0]];
        else
            exp_entry <= junk[53:0];
    end

    function automatic int kindOf(commit_t c);
        if (c.hlt) return 3;
        if (c.regWr && c.memWr) return -1;
        if (c.regWr) return 1;
        if (c.memWr) return 2;
        return 0;
    endfunction

    function automatic logic [53:0] makeExp(commit_t c);
        int k;
        logic [1:0] kk;
        logic [15:0] d;
        k  = kindOf(c);
        if (k < 0) k = 0;
        kk = 2'(k);
        d  = (k == 1) ? c.wrData : (k == 2) ? c.memData : 16'h0000;
        return {kk, c.pc, c.wrReg, c.memAddr, d};
    endfunction

    // Walk the program in order and apply the per-kind field rules.
    function automatic void predict(output int code, output int idx, output int chk, output bit ps);
        int k, c;
        logic [53:0] e;
        code = 0; idx = 0; chk = 0; ps = 1'b0;
        for (int i = 0; i < nProg; i++) begin
            k = kindOf(prog[i]);
            e = expMem[i];
            chk = i + 1;
            c = 0;
            if (k < 0 || k != int'(e[53:52])) c = 1;
            else if (PC_EN && prog[i].pc != e[51:36]) c = 2;
            else if (k == 1 && prog[i].wrReg != e[35:32]) c = 3;
            else if (k == 2 && prog[i].memAddr != e[31:16]) c = 4;
            else if ((k == 1 && prog[i].wrData != e[15:0]) ||
                     (k == 2 && prog[i].memData != e[15:0])) c = 5;
            if (c != 0) begin
                code = c; idx = i;
                return;
            end
            if (k == 3) begin
                ps = 1'b1;
                return;
            end
        end
    endfunction

    function automatic commit_t blankCommit();
        commit_t c;
        c.hlt = 0; c.regWr = 0; c.memWr = 0; c.pc = 0;
        c.wrData = 0; c.memAddr = 0; c.memData = 0; c.wrReg = 0;
        return c;
    endfunction

    task automatic setIdle();
        commit_vld = 0; pc = 0; reg_wr = 0; wr_reg = 0; wr_data = 0;
        mem_wr = 0; mem_addr = 0; mem_data = 0; hlt = 0;
    endtask

    task automatic applyCommit(commit_t c);
        commit_vld = 1; pc = c.pc; reg_wr = c.regWr; wr_reg = c.wrReg;
        wr_data = c.wrData; mem_wr = c.memWr; mem_addr = c.memAddr;
        mem_data = c.memData; hlt = c.hlt;
    endtask

    task automatic doReset();
        setIdle();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic runProgram(input int gapMax, output int cyc);
        int gap, bound;
        cyc = 0;
        for (int i = 0; i < nProg; i++) begin
            applyCommit(prog[i]);
            @(negedge clk); cyc++;
            gap = (gapMax > 0) ? $urandom_range(0, gapMax) : 0;
            if (gap > 0) begin
                setIdle();
                repeat (gap) begin @(negedge clk); cyc++; end
            end
        end
        setIdle();
        bound = 0;
        while (!done && bound < 60) begin
            @(negedge clk); cyc++; bound++;
        end
    endtask

    task automatic loadPassPath();
        for (int i = 0; i < 64; i++) begin
            prog[i] = blankCommit();
            expMem[i] = '0;
        end
        prog[0].regWr = 1; prog[0].wrReg = 4'd1; prog[0].wrData = 16'h0005; prog[0].pc = 16'h0000;
        prog[1].memWr = 1; prog[1].memAddr = 16'h0010; prog[1].memData = 16'h0005; prog[1].pc = 16'h0002;
        prog[2].pc = 16'h0004;
        prog[3].hlt = 1; prog[3].pc = 16'h0006;
        expMem[0] = {2'd1, 16'h0000, 4'd1, 16'h0000, 16'h0005};
        expMem[1] = {2'd2, 16'h0002, 4'd0, 16'h0010, 16'h0005};
        expMem[2] = {2'd0, 16'h0004, 4'd0, 16'h0000, 16'h0000};
        expMem[3] = {2'd3, 16'h0006, 4'd0, 16'h0000, 16'h0000};
        nProg = 4;
    endtask

    task automatic test_reset();
        setIdle();
        rst_n = 0;
        @(negedge clk);
        vectors++;
        if ({done, pass, err_code, exp_rd} !== 6'b0) begin
            $display("FAIL reset_flags: got done=%b pass=%b code=%0d exp_rd=%b expected all 0", done, pass, err_code, exp_rd);
            miscompares++;
        end
        vectors++;
        if (checked !== '0 || err_idx !== '0) begin
            $display("FAIL reset_counts: got checked=%0d err_idx=%0d expected 0/0", checked, err_idx);
            miscompares++;
        end
        rst_n = 1;
        #1;
        vectors++;
        if (exp_rd !== 1'b1 || exp_addr !== 16'd0) begin
            $display("FAIL prefetch_0: got exp_rd=%b addr=%0d expected 1/0", exp_rd, exp_addr);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (exp_rd !== 1'b1 || exp_addr !== 16'd1) begin
            $display("FAIL prefetch_1: got exp_rd=%b addr=%0d expected 1/1", exp_rd, exp_addr);
            miscompares++;
        end
    endtask

    task automatic test_pass_path();
        int cyc;
        loadPassPath();
        doReset();
        repeat (3) @(negedge clk);
        runProgram(0, cyc);
        vectors++;
        if (done !== 1'b1 || pass !== 1'b1 || err_code !== 3'd0) begin
            $display("FAIL pass_path: got done=%b pass=%b code=%0d expected 1/1/0", done, pass, err_code);
            miscompares++;
        end
        vectors++;
        if (checked !== 16'd4) begin
            $display("FAIL pass_checked: got %0d expected 4", checked);
            miscompares++;
        end
        vectors++;
        if (cyc > 6) begin
            $display("FAIL pass_latency: got %0d cycles expected <= 6", cyc);
            miscompares++;
        end
    endtask

    task automatic test_data_mismatch();
        int cyc;
        loadPassPath();
        prog[0].wrData = 16'h0006;
        doReset();
        runProgram(0, cyc);
        vectors++;
        if (done !== 1'b1 || pass !== 1'b0 || err_code !== 3'd5 || err_idx !== 16'd0) begin
            $display("FAIL data_mismatch: got done=%b pass=%b code=%0d idx=%0d expected 1/0/5/0", done, pass, err_code, err_idx);
            miscompares++;
        end
    endtask

    task automatic test_illegal_kind();
        int cyc;
        loadPassPath();
        prog[2].regWr = 1; prog[2].memWr = 1;
        doReset();
        runProgram(0, cyc);
        vectors++;
        if (done !== 1'b1 || pass !== 1'b0 || err_code !== 3'd1 || err_idx !== 16'd2) begin
            $display("FAIL illegal_kind: got done=%b pass=%b code=%0d idx=%0d expected 1/0/1/2", done, pass, err_code, err_idx);
            miscompares++;
        end
        for (int i = 0; i < 3; i++) begin
            applyCommit(prog[0]);
            @(negedge clk);
        end
        setIdle();
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || err_code !== 3'd1 || err_idx !== 16'd2 || checked !== 16'd3 || exp_rd !== 1'b0) begin
            $display("FAIL done_hold: got done=%b code=%0d idx=%0d checked=%0d exp_rd=%b expected 1/1/2/3/0", done, err_code, err_idx, checked, exp_rd);
            miscompares++;
        end
    endtask

    task automatic test_overflow();
        int cyc;
        loadPassPath();
        prog[4] = prog[2];
        nProg = 5;
        force dut.retLoad = 1'b0;
        doReset();
        runProgram(0, cyc);
        vectors++;
        if (done !== 1'b1 || pass !== 1'b0 || err_code !== 3'd6 || err_idx !== 16'd0 || checked !== 16'd0) begin
            $display("FAIL overflow: got done=%b pass=%b code=%0d idx=%0d checked=%0d expected 1/0/6/0/0", done, pass, err_code, err_idx, checked);
            miscompares++;
        end
        release dut.retLoad;
    endtask

    task automatic test_pc_check();
        int cyc;
        loadPassPath();
        prog[0] = blankCommit(); prog[0].pc = 16'h0008;
        prog[1] = blankCommit(); prog[1].hlt = 1; prog[1].pc = 16'h0002;
        expMem[0] = {2'd0, 16'h000A, 4'd0, 16'h0000, 16'h0000};
        expMem[1] = {2'd3, 16'h0002, 4'd0, 16'h0000, 16'h0000};
        nProg = 2;
        doReset();
        repeat (3) @(negedge clk);
        runProgram(0, cyc);
        vectors++;
        if (PC_EN) begin
            if (done !== 1'b1 || pass !== 1'b0 || err_code !== 3'd2 || err_idx !== 16'd0) begin
                $display("FAIL pc_check: got done=%b pass=%b code=%0d idx=%0d expected 1/0/2/0", done, pass, err_code, err_idx);
                miscompares++;
            end
        end else begin
            if (done !== 1'b1 || pass !== 1'b1 || err_code !== 3'd0 || checked !== 16'd2) begin
                $display("FAIL pc_ignored: got done=%b pass=%b code=%0d checked=%0d expected 1/1/0/2", done, pass, err_code, checked);
                miscompares++;
            end
        end
    endtask

    task automatic test_random();
        int n, sel, idx, cyc, eCode, eIdx, eChk;
        bit ePass;
        logic [53:0] e;
        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(3, 12);
            for (int i = 0; i < 64; i++) begin
                prog[i] = blankCommit();
                expMem[i] = {$urandom, $urandom};
            end
            for (int i = 0; i < n; i++) begin
                sel = $urandom_range(0, 2);
                prog[i].pc      = 16'($urandom);
                prog[i].wrReg   = 4'($urandom);
                prog[i].wrData  = 16'($urandom);
                prog[i].memAddr = 16'($urandom);
                prog[i].memData = 16'($urandom);
                prog[i].regWr   = (sel == 1) || (i == n - 1 && $urandom_range(0, 1) == 1);
                prog[i].memWr   = (sel == 2);
                prog[i].hlt     = (i == n - 1);
                expMem[i] = makeExp(prog[i]);
            end
            nProg = n;
            idx = $urandom_range(0, n - 1);
            sel = $urandom_range(0, 7);
            e = expMem[idx];
            case (sel)
                0: e[53:52] = e[53:52] ^ 2'($urandom_range(1, 3));
                1: e[51:36] = e[51:36] ^ 16'($urandom_range(1, 65535));
                2: e[35:32] = e[35:32] ^ 4'($urandom_range(1, 15));
                3: e[31:16] = e[31:16] ^ 16'($urandom_range(1, 65535));
                4: e[15:0]  = e[15:0]  ^ 16'($urandom_range(1, 65535));
                5: if (idx < n - 1) begin prog[idx].regWr = 1; prog[idx].memWr = 1; end
                default: ;
            endcase
            expMem[idx] = e;
            predict(eCode, eIdx, eChk, ePass);
            doReset();
            repeat (3) @(negedge clk);
            runProgram(2, cyc);
            vectors++;
            if (done !== 1'b1 || pass !== ePass) begin
                $display("FAIL rnd%0d_status: got done=%b pass=%b expected 1/%b", t, done, pass, ePass);
                miscompares++;
            end
            vectors++;
            if (err_code !== 3'(eCode)) begin
                $display("FAIL rnd%0d_code: got %0d expected %0d", t, err_code, eCode);
                miscompares++;
            end
            vectors++;
            if (err_idx !== 16'(eIdx)) begin
                $display("FAIL rnd%0d_idx: got %0d expected %0d", t, err_idx, eIdx);
                miscompares++;
            end
            vectors++;
            if (checked !== 16'(eChk)) begin
                $display("FAIL rnd%0d_checked: got %0d expected %0d", t, checked, eChk);
                miscompares++;
            end
        end
    endtask

    task automatic test_timeout();
        int edges;
        for (int i = 0; i < 64; i++) begin
            prog[i] = blankCommit();
            prog[i].pc = 16'(2 * i);
            expMem[i] = makeExp(prog[i]);
        end
        doReset();
        edges = 0;
        for (int i = 0; i < 3; i++) begin
            applyCommit(prog[i]);
            @(negedge clk); edges++;
        end
        setIdle();
        while (edges < MAXC - 1) begin
            @(negedge clk); edges++;
        end
        vectors++;
        if (done !== 1'b0) begin
            $display("FAIL timeout_early: got done=%b expected 0 at %0d cycles", done, edges);
            miscompares++;
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (done !== 1'b1 || pass !== 1'b0 || err_code !== 3'd7 || err_idx !== 16'd3 || checked !== 16'd3) begin
            $display("FAIL timeout: got done=%b pass=%b code=%0d idx=%0d checked=%0d expected 1/0/7/3/3", done, pass, err_code, err_idx, checked);
            miscompares++;
        end
        #2 rst_n = 0;
        #1;
        vectors++;
        if (done !== 1'b0 || checked !== '0 || err_code !== 3'd0) begin
            $display("FAIL async_reset: got done=%b checked=%0d code=%0d expected 0/0/0", done, checked, err_code);
            miscompares++;
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        setIdle();
        test_reset();
        test_pass_path();
        test_data_mismatch();
        test_illegal_kind();
        test_overflow();
        test_pc_check();
        test_random();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
